instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time loader that fills instruction memory from a byte stream before the core runs. It is the writing side of the instruction memory that the pc/ctrl_unit datapath reads. It accepts a length-prefixed, little-endian byte stream over a valid/ready handshake, packs the bytes into XLEN-bit words, and writes them to consecutive addresses starting at 0. It holds the core in reset until loading completes.

## Interface
- XLEN, 32, instruction width in bits; must be a multiple of 8.
- INSTR_MEM_SIZE, 256, instruction memory depth in words.
- INSTR_MEM_W, $clog2(INSTR_MEM_SIZE), word address width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle; reset value 0.
- mem_wen  out  1  one-cycle instruction memory write strobe; reset value 0.
- mem_waddr  out  INSTR_MEM_W  word write address; reset value 0.
- mem_wdata  out  XLEN  word write data; reset value 0.
- core_rst_n  out  1  reset to the core, active-low; reset value 0.
- done  out  1  load finished successfully; reset value 0.
- busy  out  1  a load is in progress; reset value 0.

## Operation
- A byte transfer occurs only on a cycle where rx_valid and rx_ready are both high.
- Stream format:
  - 1 length byte N, the number of words to load.
  - N × (XLEN/8) data bytes, least-significant byte first.
  - With LOADER_CHECKSUM_EN only: 1 trailing checksum byte.
- Valid N range is 0 to min(255, INSTR_MEM_SIZE). If N > INSTR_MEM_SIZE, the loader discards writes whose address would wrap, but still consumes all the bytes.
- FSM states: IDLE, LEN, LOAD, CSUM, DONE.
  - IDLE → LEN on start.
  - LEN → LOAD on length-byte transfer with N > 0.
  - LEN → DONE (or CSUM) on length-byte transfer with N = 0.
  - LOAD → DONE (or CSUM) after the last byte of word N−1 is transferred.
  - CSUM → DONE on checksum-byte transfer.
  - DONE → LEN on start.
- rx_ready = 1 in LEN, LOAD and CSUM; 0 in IDLE and DONE.
- busy = 1 in LEN, LOAD and CSUM.
- Byte counter (0 to XLEN/8−1) wraps per word. Word counter (INSTR_MEM_W+1 bits) counts words written.
- start while busy is ignored.
- start from DONE clears done and drives core_rst_n low in the next cycle. The counters restart at 0 and memory is overwritten from address 0.
- core_rst_n = done (registered). The core leaves reset on the same edge at which done rises.
- The stream may stall arbitrarily: rx_valid low for any number of cycles has no effect on state.

## Timing
- mem_wen is registered. It is high for exactly one cycle, the cycle after the final byte of a word is transferred.
- mem_waddr and mem_wdata are valid while mem_wen is high and hold their values afterwards.
- Back-to-back transfers at one byte per cycle are sustained, so a word is written every XLEN/8 cycles.
- done rises the cycle after the last write strobe, or the cycle after the terminating byte if N = 0.
- Reset asserted mid-load immediately returns the block to IDLE with all outputs at reset values. A partial word is never written.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A running XOR of all length and data bytes is kept.
  - The CSUM state accepts one extra byte.
  - On mismatch: go to IDLE, assert output csum_err (1 bit, reset 0, sticky until next start), leave done = 0 and keep core_rst_n = 0.
  - On match: go to DONE.
- LOADER_CHECKSUM_EN undefined: no CSUM state, no csum_err port. LOAD or LEN goes directly to DONE.

## Structure
- typedefs_pkg gains:
  - loader_state_t enum {IDLE, LEN, LOAD, CSUM, DONE}.
  - Constant LOADER_BYTES_PER_WORD = XLEN/8.
- Sub-module byte_packer: shift-in register plus byte counter. It outputs a full word and a one-cycle word_valid pulse. instr_loader owns the FSM, addressing and handshake.

## Test plan
- Basic load: start, N=2, bytes 13 05 10 00 B3 02 B5 00.
  - mem_wen pulses twice: addr 0 data 0x00100513, addr 1 data 0x00B502B3.
  - done and core_rst_n go to 1 the cycle after the second strobe.
- Stalling: same stream with rx_valid low for 3 cycles between every byte → identical writes and data; no extra strobes.
- Empty load: N=0 → no mem_wen; done = 1 one cycle after the length byte.
- Mid-load reset: rst_n low after 6 data bytes → all outputs 0 immediately, only one write occurred. A following full load succeeds from addr 0.
- Reload: start while DONE, then N=1 with word 0xDEADBEEF → done drops, core_rst_n goes to 0, addr 0 is rewritten, done returns. start pulsed while busy has no effect.
- With LOADER_CHECKSUM_EN:
  - N=1, word 0x01020304, checksum 0x05 → done.
  - Checksum 0x00 → csum_err = 1, done = 0, core_rst_n = 0.

Source files
------------

// File: rtl/typedefs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : typedefs_pkg
// Purpose  : Shared types and constants for the instruction loader path.
// Revision : 1.0
// ============================================================================
package typedefs_pkg;

    localparam int LOADER_XLEN           = 32;
    localparam int LOADER_BYTES_PER_WORD = LOADER_XLEN / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        LOAD = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Packs a little-endian byte stream into words; word_valid pulses
//            with the final byte of each word (word is combinational then).
// Revision : 1.0
// ============================================================================
module byte_packer
    import typedefs_pkg::*;
#(
    parameter int BYTES = LOADER_BYTES_PER_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic [BYTES*8-1:0] word,
    output logic               word_valid
);

    localparam int                 c_CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BYTES - 1);

    logic [c_CNT_W-1:0] r_byte_cnt;

    assign word_valid = byte_valid && (r_byte_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
        end else if (clear) begin
            r_byte_cnt <= '0;
        end else if (byte_valid) begin
            r_byte_cnt <= word_valid ? '0 : r_byte_cnt + c_CNT_W'(1);
        end
    end

    generate
        if (BYTES > 1) begin : g_multi
            // Newest byte enters at the top, so the first byte ends up lowest.
            logic [(BYTES-1)*8-1:0] r_shift;

            assign word = {byte_in, r_shift};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shift <= '0;
                end else if (clear) begin
                    r_shift <= '0;
                end else if (byte_valid) begin
                    r_shift <= word[BYTES*8-1:8];
                end
            end
        end else begin : g_single
            assign word = byte_in;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Purpose  : Boot loader filling instruction memory from a length-prefixed
//            byte stream; holds the core in reset until the load completes.
//            Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module instr_loader
    import typedefs_pkg::*;
#(
    parameter int XLEN           = LOADER_XLEN,
    parameter int INSTR_MEM_SIZE = 256,
    parameter int INSTR_MEM_W    = $clog2(INSTR_MEM_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   mem_wen,
    output logic [INSTR_MEM_W-1:0] mem_waddr,
    output logic [XLEN-1:0]        mem_wdata,
    output logic                   core_rst_n,
    output logic                   done,
    output logic                   busy
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                   csum_err
`endif
);

    localparam int c_BYTES_PER_WORD = XLEN / 8;
    // Wide enough for any length byte even when the memory is small.
    localparam int                 c_CNT_W    = (INSTR_MEM_W + 1 > 8) ? INSTR_MEM_W + 1 : 8;
    localparam logic [c_CNT_W-1:0] c_MEM_SIZE = c_CNT_W'(INSTR_MEM_SIZE);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t c_AFTER_DATA = CSUM;
`else
    localparam loader_state_t c_AFTER_DATA = DONE;
`endif

    loader_state_t          r_state;
    loader_state_t          w_next;
    logic [7:0]             r_len;
    logic [c_CNT_W-1:0]     r_word_cnt;
    logic                   r_mem_wen;
    logic [INSTR_MEM_W-1:0] r_waddr;
    logic [XLEN-1:0]        r_wdata;
    logic                   r_done;
    logic                   w_xfer;
    logic                   w_start_ok;
    logic                   w_last_word;
    logic                   w_word_valid;
    logic [XLEN-1:0]        w_word;

    assign busy        = (r_state == LEN) || (r_state == LOAD) || (r_state == CSUM);
    assign rx_ready    = busy;
    assign w_xfer      = rx_valid && rx_ready;
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_word = (r_word_cnt == (c_CNT_W'(r_len) - c_CNT_W'(1)));

    assign mem_wen    = r_mem_wen;
    assign mem_waddr  = r_waddr;
    assign mem_wdata  = r_wdata;
    assign done       = r_done;
    assign core_rst_n = r_done;

    byte_packer #(
        .BYTES      (c_BYTES_PER_WORD)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_start_ok),
        .byte_valid (w_xfer && (r_state == LOAD)),
        .byte_in    (rx_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_err;

    assign csum_err = r_csum_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum     <= '0;
            r_csum_err <= 1'b0;
        end else if (w_start_ok) begin
            r_csum     <= '0;
            r_csum_err <= 1'b0;
        end else if (w_xfer) begin
            if ((r_state == LEN) || (r_state == LOAD)) begin
                r_csum <= r_csum ^ rx_data;
            end else if ((r_state == CSUM) && (rx_data != r_csum)) begin
                r_csum_err <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) w_next = LEN;
            end
            LEN: begin
                if (w_xfer) begin
                    if (rx_data == 8'd0) w_next = c_AFTER_DATA;
                    else                 w_next = LOAD;
                end
            end
            LOAD: begin
                if (w_word_valid && w_last_word) w_next = c_AFTER_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (w_xfer) begin
                    if (rx_data == r_csum) w_next = DONE;
                    else                   w_next = IDLE;
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_mem_wen  <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_mem_wen <= 1'b0;
            // Leaving LOAD delays done by one cycle so it follows the last strobe.
            r_done    <= (w_next == DONE) && (r_state != LOAD);
            if (w_start_ok) begin
                r_word_cnt <= '0;
            end
            if ((r_state == LEN) && w_xfer) begin
                r_len <= rx_data;
            end
            if (w_word_valid) begin
                r_word_cnt <= r_word_cnt + c_CNT_W'(1);
                if (r_word_cnt < c_MEM_SIZE) begin
                    r_mem_wen <= 1'b1;
                    r_waddr   <= r_word_cnt[INSTR_MEM_W-1:0];
                    r_wdata   <= w_word;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Purpose  : Self-checking bench for instr_loader (small memory so that
//            over-length loads exercise the discarded-write path).
// Revision : 1.0
// ============================================================================
module tb_instr_loader;

    localparam int MEM_SIZE = 8;
    localparam int AW       = $clog2(MEM_SIZE);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          busy;
`ifdef LOADER_CHECKSUM_EN
    logic          csum_err;
`endif

    always #5 clk = ~clk;

    instr_loader #(
        .XLEN           (32),
        .INSTR_MEM_SIZE (MEM_SIZE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .busy       (busy)
`ifdef LOADER_CHECKSUM_EN
        ,
        .csum_err   (csum_err)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        string       name;
        int          n;
        int          stall;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_writes;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    wr_t         cap[$];
    logic [31:0] tb_words[256];

    always @(negedge clk) begin
        if (mem_wen) cap.push_back({mem_waddr, mem_wdata});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int guard;
        guard    = 0;
        rx_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
            rx_data = 8'($urandom);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("rx_ready_wait", 64'(rx_ready), 64'd1);
        tick();
        rx_valid = 1'b0;
    endtask

`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] csum_model(input int n);
        logic [7:0] x;
        x = 8'(n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) x ^= 8'(tb_words[i] >> (8 * k));
        return x;
    endfunction
`endif

    // Called right after the last stream byte of a load has been accepted.
    task automatic finish_load(input string name, input int n, input int exp_writes);
        @(negedge clk);
        if (n > 0) begin
            check($sformatf("%s last_wen", name), 64'(mem_wen), 64'(n <= MEM_SIZE));
            check($sformatf("%s done_early", name), 64'(done), 64'd0);
            @(negedge clk);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum_model(n), 0);
        @(negedge clk);
`endif
        check($sformatf("%s done", name), 64'(done), 64'd1);
        check($sformatf("%s core_rst_n", name), 64'(core_rst_n), 64'd1);
        check($sformatf("%s idle_outputs", name), 64'({busy, rx_ready, mem_wen}), 64'd0);
        check($sformatf("%s write_count", name), 64'(cap.size()), 64'(exp_writes));
        for (int i = 0; i < exp_writes && i < cap.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), 64'(cap[i].addr), 64'(i));
            check($sformatf("%s data[%0d]", name, i), 64'(cap[i].data), 64'(tb_words[i]));
        end
    endtask

    // stall < 0 selects a random gap of 0..2 cycles before every byte.
    task automatic run_load(input string name, input int n, input int stall, input int exp_writes);
        cap.delete();
        pulse_start();
        send_byte(8'(n), (stall < 0) ? int'($urandom_range(0, 2)) : stall);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++)
                send_byte(8'(tb_words[i] >> (8 * k)), (stall < 0) ? int'($urandom_range(0, 2)) : stall);
        finish_load(name, n, exp_writes);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"basic",  2,  0, 32'h00100513, 32'h00B502B3, 2};
        vecs[1] = '{"stall",  2,  3, 32'h00100513, 32'h00B502B3, 2};
        vecs[2] = '{"empty",  0,  0, 32'h0,        32'h0,        0};
        vecs[3] = '{"single", 1,  1, 32'hDEADBEEF, 32'h0,        1};
        vecs[4] = '{"wrap",   10, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, MEM_SIZE};

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({rx_ready, mem_wen, mem_waddr, mem_wdata, core_rst_n, done, busy}), 64'd0);
        tick();
        rst_n = 1'b1;

        // No start: offered bytes must be refused.
        rx_valid = 1'b1;
        rx_data  = 8'h03;
        repeat (3) tick();
        @(negedge clk);
        check("idle_no_accept", 64'({rx_ready, busy, done}), 64'd0);
        rx_valid = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            tb_words[0] = vecs[v].w0;
            tb_words[1] = vecs[v].w1;
            for (int i = 2; i < 16; i++) tb_words[i] = 32'h1000_0000 + 32'(i * 32'h0101);
            run_load(vecs[v].name, vecs[v].n, vecs[v].stall, vecs[v].exp_writes);
            tick();
        end

        for (int t = 0; t < 8; t++) begin
            int n;
            n = int'($urandom_range(0, 11));
            for (int i = 0; i < n; i++) tb_words[i] = $urandom;
            run_load($sformatf("rand%0d", t), n, -1, (n < MEM_SIZE) ? n : MEM_SIZE);
            tick();
        end

        // Reset partway through the second word.
        tb_words[0] = 32'h00100513;
        tb_words[1] = 32'h00B502B3;
        cap.delete();
        pulse_start();
        send_byte(8'd2, 0);
        for (int j = 0; j < 6; j++) send_byte(8'(tb_words[j / 4] >> (8 * (j % 4))), 0);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              64'({rx_ready, mem_wen, mem_waddr, mem_wdata, core_rst_n, done, busy}), 64'd0);
        check("midreset_writes", 64'(cap.size()), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        run_load("after_reset", 2, 0, 2);

        // Reload from DONE, with a start pulse ignored in the middle of a word.
        tb_words[0] = 32'hDEADBEEF;
        cap.delete();
        pulse_start();
        @(negedge clk);
        check("reload done_drop", 64'({done, core_rst_n}), 64'd0);
        check("reload busy", 64'(busy), 64'd1);
        send_byte(8'd1, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        pulse_start();
        @(negedge clk);
        check("reload busy_after_start", 64'(busy), 64'd1);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        finish_load("reload", 1, 1);

`ifdef LOADER_CHECKSUM_EN
        tb_words[0] = 32'h01020304;
        cap.delete();
        pulse_start();
        send_byte(8'd1, 0);
        for (int k = 0; k < 4; k++) send_byte(8'(tb_words[0] >> (8 * k)), 0);
        send_byte(8'h05, 0);
        @(negedge clk);
        check("csum_ok done", 64'({done, csum_err}), 64'b10);
        pulse_start();
        send_byte(8'd1, 0);
        for (int k = 0; k < 4; k++) send_byte(8'(tb_words[0] >> (8 * k)), 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("csum_bad", 64'({csum_err, done, core_rst_n, busy}), 64'b1000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
